// File: rtl/serial_rx_bitclk.sv
// Serial byte receiver on the system clock: start-edge resync, mid-bit sampling,
// one-cycle valid/frame_err strobes and a break state for a line held low.
module serial_rx_bitclk #(
    parameter int CLK_DIV   = 162,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   sync1_q, sync2_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       term;
    logic                   at_sample;

    assign rx_s      = sync2_q;
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        term      = (state_q == S_START) ? HALF_TERM : FULL_TERM;
        at_sample = (cnt_q == term);

        if (state_q != S_IDLE) begin
            cnt_d = at_sample ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (at_sample) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (at_sample) begin
                    // Line is LSB first, so each new bit enters at the top and walks down.
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (at_sample) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every state starts timing from zero, including IDLE after a break.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
endmodule

// File: tb/tb_serial_rx_bitclk.sv
// Directed bench for serial_rx_bitclk: a CLK_DIV=162 receiver for frame timing
// and error handling, plus a CLK_DIV=16 receiver fed with off-nominal bit periods.
`timescale 1ns/1ps
module tb_serial_rx_bitclk;
    localparam int CLK_DIV   = 162;
    localparam int CLK_DIV_B = 16;

    logic       clk = 1'b0;
    logic       rst_n, rx, rx_b;
    logic [7:0] data, data_b;
    logic       valid, frame_err, busy;
    logic       valid_b, frame_err_b, busy_b;

    int checks = 0, errors = 0;
    int cyc = 0;
    int vcnt = 0, fcnt = 0, both = 0, vcnt_b = 0, fcnt_b = 0;
    int vtimes[$];

    always #5 clk = ~clk;

    serial_rx_bitclk #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .data(data),
        .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    serial_rx_bitclk #(.CLK_DIV(CLK_DIV_B), .DATA_BITS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .data(data_b),
        .valid(valid_b), .frame_err(frame_err_b), .busy(busy_b)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            vtimes.push_back(cyc);
        end
        if (frame_err) fcnt++;
        if (valid && frame_err) both++;
        if (valid_b) vcnt_b++;
        if (frame_err_b) fcnt_b++;
    end

    // Called right after a negedge; leaves rx at the stop-bit level.
    task send_frame(input logic [7:0] b, input logic stop_bit, input int extra_hold);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CLK_DIV + extra_hold) @(negedge clk);
    endtask

    task send_frame_b(input logic [7:0] b, input realtime bitp);
        rx_b = 1'b0;
        #(bitp);
        for (int i = 0; i < 8; i++) begin
            rx_b = b[i];
            #(bitp);
        end
        rx_b = 1'b1;
        #(bitp);
        #400;
    endtask

    task test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task test_single_byte;
        int  v0, f0, lat;
        bit  seen;
        v0 = vcnt; f0 = fcnt; lat = 0; seen = 1'b0;
        @(negedge clk);
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                for (int i = 0; i < 3000 && !seen; i++) begin
                    @(posedge clk); #1;
                    lat++;
                    if (valid) seen = 1'b1;
                end
            end
        join
        checks++; if (!seen || lat != 1542) begin errors++; $display("FAIL single_latency: got %0d (seen=%0d) expected 1542", lat, seen); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", data); end
        checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL single_valid_count: got %0d expected 1", vcnt - v0); end
        checks++; if (fcnt - f0 != 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", fcnt - f0); end
    endtask

    task test_back_to_back;
        int v0, f0, q0;
        v0 = vcnt; f0 = fcnt; q0 = vtimes.size();
        @(negedge clk);
        send_frame(8'h00, 1'b1, 0);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", data); end
        send_frame(8'hFF, 1'b1, 0);
        checks++; if (data !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", data); end
        send_frame(8'h3C, 1'b1, 0);
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL b2b_data2: got %h expected 3c", data); end
        repeat (5) @(negedge clk);
        checks++; if (vcnt - v0 != 3) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 3", vcnt - v0); end
        checks++;
        if (vtimes.size() < q0 + 3) begin
            errors++; $display("FAIL b2b_spacing: got %0d pulses expected 3", vtimes.size() - q0);
        end else if (vtimes[q0+1] - vtimes[q0] != 1620 || vtimes[q0+2] - vtimes[q0+1] != 1620) begin
            errors++; $display("FAIL b2b_spacing: got %0d and %0d expected 1620", vtimes[q0+1] - vtimes[q0], vtimes[q0+2] - vtimes[q0+1]);
        end
        checks++; if (fcnt - f0 != 0) begin errors++; $display("FAIL b2b_frame_err: got %0d expected 0", fcnt - f0); end
    endtask

    task test_glitch;
        int   v0, f0;
        bit   bseen;
        logic busy83, busy84;
        v0 = vcnt; f0 = fcnt; bseen = 1'b0; busy83 = 1'b0; busy84 = 1'b1;
        @(negedge clk);
        rx = 1'b0;
        fork
            begin
                repeat (40) @(negedge clk);
                rx = 1'b1;
            end
            begin
                for (int i = 1; i <= 84; i++) begin
                    @(posedge clk); #1;
                    if (busy) bseen = 1'b1;
                    if (i == 83) busy83 = busy;
                    if (i == 84) busy84 = busy;
                end
            end
        join
        checks++; if (!bseen) begin errors++; $display("FAIL glitch_busy_seen: got 0 expected 1"); end
        checks++; if (busy83 !== 1'b1) begin errors++; $display("FAIL glitch_busy_c83: got %b expected 1", busy83); end
        checks++; if (busy84 !== 1'b0) begin errors++; $display("FAIL glitch_idle_c84: got %b expected 0", busy84); end
        repeat (10) @(negedge clk);
        checks++; if (vcnt - v0 != 0 || fcnt - f0 != 0) begin errors++; $display("FAIL glitch_no_pulse: got valid=%0d ferr=%0d expected 0 0", vcnt - v0, fcnt - f0); end
    endtask

    task test_frame_error;
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        @(negedge clk);
        send_frame(8'h55, 1'b0, 500);
        checks++; if (fcnt - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fcnt - f0); end
        checks++; if (vcnt - v0 != 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", vcnt - v0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL ferr_data_held: got %h expected 3c", data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %b expected 1", busy); end
        rx = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_until_sync: got %b expected 1", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
        repeat (10) @(negedge clk);
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h12, 1'b1, 0);
        repeat (5) @(negedge clk);
        checks++; if (vcnt - v0 != 1 || data !== 8'h12) begin errors++; $display("FAIL ferr_recover: got %0d pulses data %h expected 1 pulse data 12", vcnt - v0, data); end
        checks++; if (fcnt - f0 != 0) begin errors++; $display("FAIL ferr_recover_clean: got %0d expected 0", fcnt - f0); end
    endtask

    task test_reset_mid;
        int         v0, f0;
        logic [7:0] b;
        b = 8'h81;
        @(negedge clk);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = b[4];
        repeat (CLK_DIV / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_async: got %b expected 0", busy); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", data); end
        @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        v0 = vcnt; f0 = fcnt;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (vcnt - v0 != 0 || fcnt - f0 != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_aborted: got valid=%0d ferr=%0d busy=%b expected 0 0 0", vcnt - v0, fcnt - f0, busy); end
        send_frame(8'h7E, 1'b1, 0);
        repeat (5) @(negedge clk);
        checks++; if (vcnt - v0 != 1 || data !== 8'h7E) begin errors++; $display("FAIL rst_mid_next: got %0d pulses data %h expected 1 pulse data 7e", vcnt - v0, data); end
    endtask

    task test_baud_tolerance;
        logic [7:0] bytes [4];
        realtime    periods [4];
        int         v0;
        bytes   = '{8'hA5, 8'h5A, 8'hC3, 8'h0F};
        periods = '{155.0, 165.0, 155.0, 165.0};
        @(negedge clk);
        #3;
        for (int k = 0; k < 4; k++) begin
            v0 = vcnt_b;
            send_frame_b(bytes[k], periods[k]);
            checks++;
            if (vcnt_b - v0 != 1 || data_b !== bytes[k]) begin
                errors++; $display("FAIL baud_frame%0d: got %0d pulses data %h expected 1 pulse data %h", k, vcnt_b - v0, data_b, bytes[k]);
            end
        end
        checks++; if (fcnt_b != 0) begin errors++; $display("FAIL baud_frame_err: got %0d expected 0", fcnt_b); end
    endtask

    task test_exclusive;
        checks++; if (both != 0) begin errors++; $display("FAIL valid_and_frame_err: got %0d overlapping cycles expected 0", both); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid();
        test_baud_tolerance();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
